// File: rtl/trg_seq_ctrl.sv
// Trigger sequencer: merges hit and external trigger requests, issues a fixed-width
// trigger pulse, then holds off through a latched dead time and any downstream busy.
module trg_seq_ctrl #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned DEAD_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hit_trg_i,
    input  logic              ext_trig_i,
    input  logic              ext_en_i,
    input  logic              busy_i,
    input  logic [3:0]        si_busy_i,
    input  logic [DEAD_W-1:0] dead_cfg_i,
    input  logic              cnt_clr_i,
    output logic              logic_trg_o,
    output logic              trg_src_o,
    output logic [31:0]       trg_cnt_o,
    output logic [15:0]       lost_cnt_o,
    output logic              dead_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIRE      = 2'd1,
        DEAD      = 2'd2,
        WAIT_BUSY = 2'd3
    } state_t;

    localparam logic [3:0]        PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE   = 1;

    state_t            state_q, state_d;
    logic [3:0]        pulse_cnt_q, pulse_cnt_d;
    logic [DEAD_W-1:0] dead_len_q, dead_len_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              logic_trg_q, logic_trg_d;
    logic              dead_q, dead_d;
    logic              trg_src_q, trg_src_d;
    logic [31:0]       trg_cnt_q, trg_cnt_d;
    logic [15:0]       lost_cnt_q, lost_cnt_d;

    logic req;
    logic blk;
    logic accept;
    logic reject;

    assign req    = hit_trg_i | (ext_trig_i & ext_en_i);
    assign blk    = busy_i | (|si_busy_i);
    assign accept = (state_q == IDLE) & req & ~blk;
    assign reject = req & ((state_q != IDLE) | blk);

    // Once the fixed hold-off ends, WAIT_BUSY is only entered when something is still busy.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        dead_len_d  = dead_len_q;
        dead_cnt_d  = dead_cnt_q;
        trg_src_d   = trg_src_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = FIRE;
                    pulse_cnt_d = '0;
                    dead_len_d  = dead_cfg_i;
                    trg_src_d   = ~hit_trg_i;
                end
            end
            FIRE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    if (dead_len_q != '0) begin
                        state_d    = DEAD;
                        dead_cnt_d = dead_len_q - DEAD_ONE;
                    end else begin
                        state_d = blk ? WAIT_BUSY : IDLE;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 4'd1;
                end
            end
            DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = blk ? WAIT_BUSY : IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_ONE;
                end
            end
            WAIT_BUSY: begin
                if (!blk) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        logic_trg_d = (state_d == FIRE);
        dead_d      = (state_d != IDLE);

        trg_cnt_d = trg_cnt_q;
        if (cnt_clr_i) begin
            trg_cnt_d = '0;
        end else if (accept && (trg_cnt_q != '1)) begin
            trg_cnt_d = trg_cnt_q + 32'd1;
        end

        lost_cnt_d = lost_cnt_q;
        if (cnt_clr_i) begin
            lost_cnt_d = '0;
        end else if (reject && (lost_cnt_q != '1)) begin
            lost_cnt_d = lost_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            dead_len_q  <= '0;
            dead_cnt_q  <= '0;
            logic_trg_q <= 1'b0;
            dead_q      <= 1'b0;
            trg_src_q   <= 1'b0;
            trg_cnt_q   <= '0;
            lost_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            dead_len_q  <= dead_len_d;
            dead_cnt_q  <= dead_cnt_d;
            logic_trg_q <= logic_trg_d;
            dead_q      <= dead_d;
            trg_src_q   <= trg_src_d;
            trg_cnt_q   <= trg_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign logic_trg_o = logic_trg_q;
    assign dead_o      = dead_q;
    assign trg_src_o   = trg_src_q;
    assign trg_cnt_o   = trg_cnt_q;
    assign lost_cnt_o  = lost_cnt_q;

endmodule

// File: tb/tb_trg_seq_ctrl.sv
// Bench for trg_seq_ctrl: directed scenarios plus randomized traffic, compared against a
// cycle-count reference model of the trigger/hold-off behaviour.
module tb_trg_seq_ctrl;

    localparam int PULSE_W = 4;
    localparam int DEAD_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              hit_trg_i;
    logic              ext_trig_i;
    logic              ext_en_i;
    logic              busy_i;
    logic [3:0]        si_busy_i;
    logic [DEAD_W-1:0] dead_cfg_i;
    logic              cnt_clr_i;
    logic              logic_trg_o;
    logic              trg_src_o;
    logic [31:0]       trg_cnt_o;
    logic [15:0]       lost_cnt_o;
    logic              dead_o;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining pulse cycles, remaining dead cycles, and a busy-wait flag.
    int          m_pulse_left;
    int          m_hold_left;
    bit          m_wait;
    bit          m_src;
    logic [31:0] m_trg_cnt;
    logic [15:0] m_lost_cnt;

    trg_seq_ctrl #(.PULSE_W(PULSE_W), .DEAD_W(DEAD_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hit_trg_i  (hit_trg_i),
        .ext_trig_i (ext_trig_i),
        .ext_en_i   (ext_en_i),
        .busy_i     (busy_i),
        .si_busy_i  (si_busy_i),
        .dead_cfg_i (dead_cfg_i),
        .cnt_clr_i  (cnt_clr_i),
        .logic_trg_o(logic_trg_o),
        .trg_src_o  (trg_src_o),
        .trg_cnt_o  (trg_cnt_o),
        .lost_cnt_o (lost_cnt_o),
        .dead_o     (dead_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit m_busy();
        return (m_pulse_left > 0) || (m_hold_left > 0) || m_wait;
    endfunction

    task automatic model_reset();
        m_pulse_left = 0;
        m_hold_left  = 0;
        m_wait       = 1'b0;
        m_src        = 1'b0;
        m_trg_cnt    = '0;
        m_lost_cnt   = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit req;
        bit blk;
        bit was_busy;
        req      = hit_trg_i || (ext_trig_i && ext_en_i);
        blk      = busy_i || (si_busy_i != 4'b0000);
        was_busy = m_busy();
        if (cnt_clr_i) begin
            m_trg_cnt  = '0;
            m_lost_cnt = '0;
        end else begin
            if (req && (was_busy || blk) && (m_lost_cnt != 16'hFFFF)) m_lost_cnt = m_lost_cnt + 16'd1;
            if (req && !was_busy && !blk && (m_trg_cnt != 32'hFFFF_FFFF)) m_trg_cnt = m_trg_cnt + 32'd1;
        end
        if (!was_busy) begin
            if (req && !blk) begin
                m_pulse_left = PULSE_W;
                m_hold_left  = int'(dead_cfg_i);
                m_wait       = 1'b0;
                m_src        = !hit_trg_i;
            end
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
            if (m_pulse_left == 0 && m_hold_left == 0) m_wait = blk;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_wait = blk;
        end else begin
            m_wait = blk;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet_inputs();
        hit_trg_i  = 1'b0;
        ext_trig_i = 1'b0;
        ext_en_i   = 1'b0;
        busy_i     = 1'b0;
        si_busy_i  = 4'b0000;
        cnt_clr_i  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        quiet_inputs();
        while (dead_o !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (dead_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle_timeout: dead_o=%b expected 0", tag, dead_o);
        end
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        dead_cfg_i = '0;
        quiet_inputs();
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (logic_trg_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_trg: got %b expected 0", logic_trg_o); end
        checks++; if (dead_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_dead: got %b expected 0", dead_o); end
        checks++; if (trg_src_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_src: got %b expected 0", trg_src_o); end
        checks++; if (trg_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_trg_cnt: got %0d expected 0", trg_cnt_o); end
        checks++; if (lost_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_lost_cnt: got %0d expected 0", lost_cnt_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_hit();
        int hi;
        int dd;
        hi = 0;
        dd = 0;
        dead_cfg_i = 16'd10;
        hit_trg_i  = 1'b1;
        tick();
        hit_trg_i  = 1'b0;
        dead_cfg_i = 16'd2;
        checks++; if (logic_trg_o !== 1'b1) begin errors++; $display("[TB] FAIL hit_pulse_start: got %b expected 1", logic_trg_o); end
        for (int i = 0; i < 20; i++) begin
            if (logic_trg_o === 1'b1) hi++;
            if (dead_o === 1'b1) dd++;
            checks++;
            if (dead_o !== m_busy()) begin errors++; $display("[TB] FAIL hit_dead_cycle%0d: got %b expected %b", i, dead_o, m_busy()); end
            tick();
        end
        checks++; if (hi != PULSE_W) begin errors++; $display("[TB] FAIL hit_pulse_width: got %0d expected %0d", hi, PULSE_W); end
        checks++; if (dd != 14) begin errors++; $display("[TB] FAIL hit_dead_width: got %0d expected 14", dd); end
        checks++; if (trg_cnt_o !== 32'd1) begin errors++; $display("[TB] FAIL hit_trg_cnt: got %0d expected 1", trg_cnt_o); end
        checks++; if (trg_src_o !== 1'b0) begin errors++; $display("[TB] FAIL hit_src: got %b expected 0", trg_src_o); end
        wait_idle("single_hit");
    endtask

    task automatic test_coincident();
        dead_cfg_i = 16'd3;
        cnt_clr_i  = 1'b1;
        tick();
        cnt_clr_i  = 1'b0;
        hit_trg_i  = 1'b1;
        ext_trig_i = 1'b1;
        ext_en_i   = 1'b1;
        tick();
        quiet_inputs();
        checks++; if (logic_trg_o !== 1'b1) begin errors++; $display("[TB] FAIL both_pulse: got %b expected 1", logic_trg_o); end
        checks++; if (trg_src_o !== 1'b0) begin errors++; $display("[TB] FAIL both_src: got %b expected 0", trg_src_o); end
        checks++; if (trg_cnt_o !== 32'd1) begin errors++; $display("[TB] FAIL both_trg_cnt: got %0d expected 1", trg_cnt_o); end
        checks++; if (lost_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL both_lost_cnt: got %0d expected 0", lost_cnt_o); end
        wait_idle("coincident");
        ext_trig_i = 1'b1;
        ext_en_i   = 1'b1;
        tick();
        quiet_inputs();
        checks++; if (trg_src_o !== 1'b1) begin errors++; $display("[TB] FAIL ext_src: got %b expected 1", trg_src_o); end
        checks++; if (trg_cnt_o !== 32'd2) begin errors++; $display("[TB] FAIL ext_trg_cnt: got %0d expected 2", trg_cnt_o); end
        wait_idle("ext_only");
    endtask

    task automatic test_ext_disabled_and_lost();
        dead_cfg_i = 16'd3;
        cnt_clr_i  = 1'b1;
        tick();
        cnt_clr_i  = 1'b0;
        ext_trig_i = 1'b1;
        ext_en_i   = 1'b0;
        tick();
        quiet_inputs();
        checks++; if (logic_trg_o !== 1'b0 || dead_o !== 1'b0) begin errors++; $display("[TB] FAIL ext_dis_pulse: trg=%b dead=%b expected 0 0", logic_trg_o, dead_o); end
        checks++; if (trg_cnt_o !== 32'd0 || lost_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL ext_dis_counts: trg=%0d lost=%0d expected 0 0", trg_cnt_o, lost_cnt_o); end
        hit_trg_i = 1'b1;
        tick();
        hit_trg_i = 1'b0;
        repeat (PULSE_W) tick();
        checks++; if (logic_trg_o !== 1'b0 || dead_o !== 1'b1) begin errors++; $display("[TB] FAIL in_dead: trg=%b dead=%b expected 0 1", logic_trg_o, dead_o); end
        hit_trg_i = 1'b1;
        tick();
        hit_trg_i = 1'b0;
        checks++; if (lost_cnt_o !== 16'd1) begin errors++; $display("[TB] FAIL dead_lost: got %0d expected 1", lost_cnt_o); end
        checks++; if (trg_cnt_o !== 32'd1) begin errors++; $display("[TB] FAIL dead_trg_cnt: got %0d expected 1", trg_cnt_o); end
        wait_idle("dead_lost");
    endtask

    task automatic test_wait_busy();
        int waits;
        waits = 0;
        dead_cfg_i = 16'd3;
        hit_trg_i  = 1'b1;
        tick();
        hit_trg_i  = 1'b0;
        repeat (PULSE_W + 2) tick();
        checks++; if (logic_trg_o !== 1'b0 || dead_o !== 1'b1) begin errors++; $display("[TB] FAIL last_dead: trg=%b dead=%b expected 0 1", logic_trg_o, dead_o); end
        si_busy_i = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dead_o === 1'b1) waits++;
        end
        si_busy_i = 4'b0000;
        checks++; if (waits != 20) begin errors++; $display("[TB] FAIL wait_busy_len: got %0d expected 20", waits); end
        tick();
        checks++; if (dead_o !== 1'b0) begin errors++; $display("[TB] FAIL wait_release: got %b expected 0", dead_o); end
    endtask

    task automatic test_zero_dead();
        int dd;
        dd = 0;
        dead_cfg_i = 16'd0;
        hit_trg_i  = 1'b1;
        tick();
        hit_trg_i  = 1'b0;
        busy_i     = 1'b1;
        repeat (PULSE_W) tick();
        checks++; if (logic_trg_o !== 1'b0 || dead_o !== 1'b1) begin errors++; $display("[TB] FAIL zero_dead_wait: trg=%b dead=%b expected 0 1", logic_trg_o, dead_o); end
        repeat (3) tick();
        checks++; if (dead_o !== 1'b1) begin errors++; $display("[TB] FAIL zero_dead_hold: got %b expected 1", dead_o); end
        busy_i = 1'b0;
        tick();
        checks++; if (dead_o !== 1'b0) begin errors++; $display("[TB] FAIL zero_dead_release: got %b expected 0", dead_o); end
        hit_trg_i = 1'b1;
        tick();
        hit_trg_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dead_o === 1'b1) dd++;
            tick();
        end
        checks++; if (dd != PULSE_W) begin errors++; $display("[TB] FAIL zero_dead_width: got %0d expected %0d", dd, PULSE_W); end
    endtask

    task automatic test_lost_saturation();
        logic [31:0] trg_before;
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i  = 1'b0;
        trg_before = m_trg_cnt;
        hit_trg_i  = 1'b1;
        busy_i     = 1'b1;
        repeat (65532) tick();
        checks++; if (lost_cnt_o !== 16'hFFFC) begin errors++; $display("[TB] FAIL lost_preset: got %h expected fffc", lost_cnt_o); end
        repeat (3) tick();
        checks++; if (lost_cnt_o !== 16'hFFFF) begin errors++; $display("[TB] FAIL lost_sat: got %h expected ffff", lost_cnt_o); end
        repeat (2) tick();
        checks++; if (lost_cnt_o !== 16'hFFFF) begin errors++; $display("[TB] FAIL lost_hold: got %h expected ffff", lost_cnt_o); end
        checks++; if (trg_cnt_o !== trg_before) begin errors++; $display("[TB] FAIL lost_trg_cnt: got %0d expected %0d", trg_cnt_o, trg_before); end
        cnt_clr_i = 1'b1;
        tick();
        checks++; if (lost_cnt_o !== 16'd0 || trg_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL clr_priority: lost=%0d trg=%0d expected 0 0", lost_cnt_o, trg_cnt_o); end
        wait_idle("saturation");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            hit_trg_i  = ($urandom_range(0, 9) == 0);
            ext_trig_i = ($urandom_range(0, 9) == 0);
            ext_en_i   = $urandom_range(0, 1) == 1;
            busy_i     = ($urandom_range(0, 7) == 0);
            si_busy_i  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            dead_cfg_i = 16'($urandom_range(0, 6));
            cnt_clr_i  = ($urandom_range(0, 63) == 0);
            tick();
            checks++; if (logic_trg_o !== (m_pulse_left > 0)) begin errors++; $display("[TB] FAIL rnd_trg@%0d: got %b expected %b", i, logic_trg_o, (m_pulse_left > 0)); end
            checks++; if (dead_o !== m_busy()) begin errors++; $display("[TB] FAIL rnd_dead@%0d: got %b expected %b", i, dead_o, m_busy()); end
            checks++; if (trg_src_o !== m_src) begin errors++; $display("[TB] FAIL rnd_src@%0d: got %b expected %b", i, trg_src_o, m_src); end
            checks++; if (trg_cnt_o !== m_trg_cnt) begin errors++; $display("[TB] FAIL rnd_trg_cnt@%0d: got %0d expected %0d", i, trg_cnt_o, m_trg_cnt); end
            checks++; if (lost_cnt_o !== m_lost_cnt) begin errors++; $display("[TB] FAIL rnd_lost_cnt@%0d: got %0d expected %0d", i, lost_cnt_o, m_lost_cnt); end
        end
        wait_idle("random");
    endtask

    task automatic test_reset_mid_pulse();
        int late;
        late = 0;
        dead_cfg_i = 16'd5;
        hit_trg_i  = 1'b1;
        tick();
        hit_trg_i  = 1'b0;
        tick();
        #3;
        rst_i = 1'b1;
        #1;
        model_reset();
        checks++; if (logic_trg_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_trg: got %b expected 0", logic_trg_o); end
        checks++; if (dead_o !== 1'b0 || trg_src_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_flags: dead=%b src=%b expected 0 0", dead_o, trg_src_o); end
        checks++; if (trg_cnt_o !== 32'd0 || lost_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_counts: trg=%0d lost=%0d expected 0 0", trg_cnt_o, lost_cnt_o); end
        hit_trg_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++; if (logic_trg_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_held_req: got %b expected 0", logic_trg_o); end
        hit_trg_i = 1'b0;
        rst_i     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (logic_trg_o !== 1'b0) late++;
        end
        checks++; if (late != 0) begin errors++; $display("[TB] FAIL rst_no_completion: got %0d high cycles expected 0", late); end
        rst_i     = 1'b1;
        hit_trg_i = 1'b1;
        @(posedge clk_i);
        #1;
        model_reset();
        rst_i = 1'b0;
        tick();
        hit_trg_i = 1'b0;
        checks++; if (logic_trg_o !== 1'b1 || trg_cnt_o !== 32'd1) begin errors++; $display("[TB] FAIL rst_first_edge_req: trg=%b cnt=%0d expected 1 1", logic_trg_o, trg_cnt_o); end
        wait_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_coincident();
        test_ext_disabled_and_lost();
        test_wait_busy();
        test_zero_dead();
        test_lost_saturation();
        test_random();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
